// File: rtl/avgpool10.sv
// Global average pool over POSITIONS spatial samples of a CH-wide vector;
// averages are streamed one channel per transfer with valid/ready handshake.
module avgpool10 #(
  parameter int CH        = 512,
  parameter int WIDTH     = 16,
  parameter int POSITIONS = 64,
  parameter int ACC_W     = WIDTH + $clog2(POSITIONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pool_en,
  input  logic                   sample,
  input  logic [WIDTH-1:0]       ofm_in [0:CH-1],
  output logic [WIDTH-1:0]       pool_out,
  output logic [$clog2(CH)-1:0]  pool_ch,
  output logic                   pool_valid,
  input  logic                   pool_ready,
  output logic                   pool_end,
  output logic                   sample_drop
);

  // state  | meaning
  // IDLE   | waiting for pool_en, accumulators already zero
  // ACCUM  | summing one position vector per sample strobe
  // STREAM | presenting channel averages, one per accepted transfer
  // DONE   | all channels delivered, pool_end held until pool_en drops
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int SH = $clog2(POSITIONS);
  localparam int CW = $clog2(CH);
  localparam int PW = $clog2(POSITIONS + 1);

  logic [1:0]       state;
  logic [ACC_W-1:0] acc [0:CH-1];
  logic [PW-1:0]    pos;
  logic [CW-1:0]    ch_nxt;
  logic [ACC_W-1:0] sum0;
  logic [WIDTH-1:0] avg0;
  logic [WIDTH-1:0] avg_nxt;

  assign ch_nxt  = pool_ch + 1'b1;
  // channel 0 average must be ready on the edge of the final capture
  assign sum0    = acc[0] + ACC_W'(ofm_in[0]);
  assign avg0    = WIDTH'(sum0 >> SH);
  assign avg_nxt = WIDTH'(acc[ch_nxt] >> SH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pos         <= '0;
      pool_ch     <= '0;
      pool_out    <= '0;
      pool_valid  <= 1'b0;
      pool_end    <= 1'b0;
      sample_drop <= 1'b0;
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else begin
      if (sample && state != S_ACCUM) sample_drop <= 1'b1;
      if (!pool_en) begin
        state      <= S_IDLE;
        pos        <= '0;
        pool_ch    <= '0;
        pool_out   <= '0;
        pool_valid <= 1'b0;
        pool_end   <= 1'b0;
        for (int i = 0; i < CH; i++) acc[i] <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state       <= S_ACCUM;
            sample_drop <= sample;
          end
          S_ACCUM: begin
            if (sample) begin
              for (int i = 0; i < CH; i++) acc[i] <= acc[i] + ACC_W'(ofm_in[i]);
              pos <= pos + 1'b1;
              if (pos == PW'(POSITIONS - 1)) begin
                state      <= S_STREAM;
                pool_valid <= 1'b1;
                pool_out   <= avg0;
              end
            end
          end
          S_STREAM: begin
            if (pool_ready) begin
              if (pool_ch == CW'(CH - 1)) begin
                state      <= S_DONE;
                pool_valid <= 1'b0;
                pool_end   <= 1'b1;
              end else begin
                pool_ch  <= ch_nxt;
                pool_out <= avg_nxt;
              end
            end
          end
          default: pool_end <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avgpool10.sv
// Directed bench for avgpool10: stimulus tasks feed a per-channel sum model,
// a negedge monitor checks every presented channel against sum/POSITIONS.
module tb_avgpool10;
  localparam int CH = 512;
  localparam int WIDTH = 16;
  localparam int POS = 64;

  logic             clk = 0;
  logic             rst = 0;
  logic             pool_en = 0;
  logic             sample = 0;
  logic [WIDTH-1:0] ofm_in [0:CH-1];
  logic [WIDTH-1:0] pool_out;
  logic [8:0]       pool_ch;
  logic             pool_valid;
  logic             pool_ready = 0;
  logic             pool_end;
  logic             sample_drop;

  avgpool10 #(.CH(CH), .WIDTH(WIDTH), .POSITIONS(POS)) dut (
    .clk(clk), .rst(rst), .pool_en(pool_en), .sample(sample), .ofm_in(ofm_in),
    .pool_out(pool_out), .pool_ch(pool_ch), .pool_valid(pool_valid),
    .pool_ready(pool_ready), .pool_end(pool_end), .sample_drop(sample_drop)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  longint sums [0:CH-1];
  int     obs  [0:CH-1];
  int     exp_ch = 0;
  int     transfers = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int val(input int mode, input int k, input int i);
    case (mode)
      0: return 64;
      1: return i * 4;
      2: return 65535;
      3: return k;
      4: return 10;
      default: return 77;
    endcase
  endfunction

  // Monitor: channel order, averages, and pool_end exclusivity
  always @(negedge clk) begin
    if (rst) begin
      if (pool_end) chk("end_with_valid", pool_valid, 0);
      if (pool_valid) begin
        chk("stream_ch", pool_ch, exp_ch);
        chk("stream_out", pool_out, sums[exp_ch] / POS);
        obs[exp_ch] = pool_out;
        if (pool_ready && pool_en) begin
          exp_ch++;
          transfers++;
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < CH; i++) begin
      sums[i] = 0;
      obs[i]  = -1;
    end
    exp_ch = 0;
    transfers = 0;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    pool_en = 0; sample = 0; pool_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic accum(input int mode, input int n, input bit entry_sample);
    clear_model();
    for (int i = 0; i < CH; i++) ofm_in[i] = 999;
    pool_en = 1; sample = entry_sample;
    @(posedge clk); #1;
    sample = 0;
    chk("drop_after_entry", sample_drop, entry_sample);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < CH; i++) begin
        ofm_in[i] = WIDTH'(val(mode, k, i));
        sums[i] += val(mode, k, i);
      end
      sample = 1;
      @(posedge clk); #1;
      sample = 0;
      if (k == POS - 2) chk("valid_before_last", pool_valid, 0);
    end
    if (n == POS) begin
      chk("first_valid", pool_valid, 1);
      chk("first_ch", pool_ch, 0);
    end
  endtask

  task automatic stream(input bit toggle, input int drop_at, input int abort_at);
    bit done = 0;
    bit dropped = 0;
    pool_ready = 1;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (pool_end) begin
        done = 1;
      end else if (exp_ch == abort_at) begin
        pool_en = 0;
        @(posedge clk); #1;
        chk("abort_valid", pool_valid, 0);
        chk("abort_end", pool_end, 0);
        chk("abort_transfers", transfers, abort_at);
        repeat (3) @(posedge clk);
        #1 chk("abort_end_later", pool_end, 0);
        return;
      end else begin
        if (toggle) pool_ready = c[0];
        if (exp_ch == drop_at && !dropped) begin
          chk("drop_before", sample_drop, 0);
          sample = 1;
          dropped = 1;
          @(posedge clk); #1;
          sample = 0;
          chk("drop_set", sample_drop, 1);
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    chk("stream_finished", done, 1);
    chk("transfers", transfers, CH);
    chk("end_held", pool_end, 1);
    chk("valid_off_done", pool_valid, 0);
    @(posedge clk); #1;
    chk("end_held2", pool_end, 1);
  endtask

  initial begin
    for (int i = 0; i < CH; i++) ofm_in[i] = 0;
    clear_model();
    #12;
    chk("rst_valid", pool_valid, 0);
    chk("rst_end", pool_end, 0);
    chk("rst_out", pool_out, 0);
    chk("rst_ch", pool_ch, 0);
    chk("rst_drop", sample_drop, 0);
    rst = 1;
    @(posedge clk); #1;

    // uniform 64, full-rate consumer
    accum(0, POS, 0);
    stream(0, -1, -1);
    chk("pin_m0_ch0", obs[0], 64);
    chk("pin_m0_ch511", obs[511], 64);
    go_idle();

    // ramp i*4, plus a strobe on the entry edge that must be ignored
    accum(1, POS, 1);
    stream(0, -1, -1);
    chk("pin_m1_ch100", obs[100], 400);
    chk("pin_m1_ch511", obs[511], 2044);
    go_idle();

    // all 0xFFFF with ready toggling
    accum(2, POS, 0);
    stream(1, -1, -1);
    chk("pin_m2_ch7", obs[7], 65535);
    chk("pin_m2_ch511", obs[511], 65535);
    go_idle();

    // sample k carries value k
    accum(3, POS, 0);
    stream(0, -1, -1);
    chk("pin_m3_ch300", obs[300], 31);
    go_idle();

    // reset pulse mid-accumulation discards partial sums
    accum(5, 30, 0);
    rst = 0; pool_en = 0;
    #3;
    chk("midrst_valid", pool_valid, 0);
    chk("midrst_out", pool_out, 0);
    #4 rst = 1;
    repeat (3) @(posedge clk);
    #1 chk("midrst_idle_valid", pool_valid, 0);
    accum(4, POS, 0);
    stream(0, -1, -1);
    chk("pin_m4_ch42", obs[42], 10);
    go_idle();

    // strobe during stream at ch 100, abort at ch 200
    accum(0, POS, 0);
    stream(0, 100, 200);
    chk("pin_m0b_ch150", obs[150], 64);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/avgpool10.md
AVGPOOL10 -- requirements
Module: avgpool10

Interface
REQ-001 SHALL have parameter CH, default 512, number of channels per captured vector.
REQ-002 SHALL have parameter WIDTH, default 16, bit width of each channel value.
REQ-003 SHALL have parameter POSITIONS, default 64, number of spatial positions (8*8) averaged.
REQ-004 SHALL have parameter ACC_W, default WIDTH+$clog2(POSITIONS) (22), accumulator width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 pool_en  input  1  layer enable; high for the whole pooling operation.
REQ-008 sample  input  1  single-cycle strobe; ofm_in holds one valid position vector.
REQ-009 ofm_in  input  WIDTH x [0:CH-1]  unpacked array of post-ReLU unsigned channel values from the conv10 stage.
REQ-010 pool_out  output  WIDTH  averaged value of channel pool_ch.
REQ-011 pool_ch  output  $clog2(CH) (9)  channel index of pool_out.
REQ-012 pool_valid  output  1  pool_out/pool_ch valid.
REQ-013 pool_ready  input  1  consumer accepts the current channel.
REQ-014 pool_end  output  1  all CH averages delivered.
REQ-015 sample_drop  output  1  sticky flag: a sample arrived outside ACCUM.

Function
REQ-016 SHALL implement states IDLE, ACCUM, STREAM, DONE.
REQ-017 IDLE -> ACCUM on the first clk where pool_en=1; all accumulators and position counter are already zero in IDLE.
REQ-018 In ACCUM, when sample=1: acc[i] <= acc[i] + zero-extended ofm_in[i] for every i, all in the same cycle; position counter increments.
REQ-019 The capture that brings the position count to POSITIONS SHALL move the state to STREAM on the next edge; the position counter SHALL not wrap before that.
REQ-020 Arithmetic: acc unsigned, ACC_W bits, no overflow possible (64*0xFFFF < 2^22); average = acc[i][ACC_W-1:$clog2(POSITIONS)] (truncating shift right by 6), exactly WIDTH bits, no rounding, no saturation needed.
REQ-021 In STREAM: pool_valid=1, pool_ch=current index starting at 0, pool_out=average of acc[pool_ch]; pool_out/pool_ch SHALL be registered and stable while pool_valid=1 and pool_ready=0.
REQ-022 Transfer occurs on a clk edge with pool_valid=1 and pool_ready=1; pool_ch then increments, and the next channel is presented on the following cycle (one transfer per cycle sustained when pool_ready stays high).
REQ-023 Transfer of channel CH-1 SHALL move the state to DONE; pool_valid=0 from the next cycle.
REQ-024 In DONE, pool_end=1 and held; pool_end SHALL never be high in any other state.
REQ-025 pool_en=0 in any state SHALL return to IDLE on the next edge, clearing accumulators, counters, pool_valid, pool_end (abort; no partial results emitted).
REQ-026 sample=1 in IDLE, STREAM or DONE SHALL be ignored for accumulation and SHALL set sample_drop; sample_drop clears only on reset or on IDLE -> ACCUM.
REQ-027 sample=1 on the same edge as IDLE -> ACCUM SHALL be ignored and SHALL set sample_drop (first capture is the cycle after entry).
REQ-028 First pool_valid SHALL assert exactly one cycle after the final sample capture.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, all acc=0, position counter=0, pool_ch=0, pool_out=0, pool_valid=0, pool_end=0, sample_drop=0.
REQ-030 Reset asserted mid-ACCUM or mid-STREAM SHALL discard all partial data; after release the block waits in IDLE for pool_en.

Verification
REQ-031 All channels ofm_in=64 for 64 samples, pool_ready=1 -> 512 consecutive transfers, pool_out=64 each, pool_ch 0..511, pool_end=1 after ch 511.
REQ-032 ofm_in[i]=i*4 on every sample, 64 samples -> pool_out for channel i = i*4; ofm_in=0xFFFF on all 64 samples -> every pool_out=0xFFFF; sample k carrying value k (0..63) -> pool_out=31 (2016>>6).
REQ-033 pool_ready toggling 1/0 each cycle in STREAM -> pool_out/pool_ch held while ready=0, no channel skipped or repeated, 512 transfers total.
REQ-034 rst pulsed low after 30 samples, then pool_en high and 64 samples of value 10 -> all pool_out=10 (no residue from earlier 30).
REQ-035 sample strobe during STREAM (channel 100) -> sample_drop=1, remaining outputs unchanged; pool_en dropped at channel 200 -> IDLE next cycle, pool_valid=0, pool_end stays 0.
